// File: rtl/ls_arb_pkg.sv
// ls_arb_pkg: shared types and the round-robin pick helper for ls_req_arbiter.
package ls_arb_pkg;

   localparam int LS_ARB_MAX_REQ = 8;
   localparam int LS_ARB_IDX_W   = $clog2(LS_ARB_MAX_REQ);

   typedef enum logic {IDLE, HOLD} ls_arb_state_t;

   // First asserted request at or after ptr, wrapping. Requests beyond the real
   // port count are zero, so the 8-wide wrap skips them and behaves as mod NUM_REQ.
   function automatic logic [LS_ARB_IDX_W-1:0] rr_pick(
      input logic [LS_ARB_MAX_REQ-1:0] req,
      input logic [LS_ARB_IDX_W-1:0]   ptr
   );
      logic [LS_ARB_IDX_W-1:0] idx;
      logic                    found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < LS_ARB_MAX_REQ; i++) begin
         idx = ptr + LS_ARB_IDX_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/ls_tag_fifo.sv
// ls_tag_fifo: in-order FIFO holding the requester index of each accepted request.
module ls_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Tag storage: data only, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + (PW+1)'(1);
         else if (do_pop && !do_push) count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/ls_req_arbiter.sv
// ls_req_arbiter: shares one load_store_top request/response port among NUM_REQ
// requesters with round-robin grants and in-order response routing.
// Build option: define LS_ARB_PRIO0_EN to make requester 0 strict-priority
// (round-robin then applies among requesters 1..NUM_REQ-1).
module ls_req_arbiter
   import ls_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUTST  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             s_req_valid,
   output logic [NUM_REQ-1:0]             s_req_ready,
   input  logic [NUM_REQ-1:0]             s_req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_req_wdata,
   output logic [NUM_REQ-1:0]             s_resp_valid,
   input  logic [NUM_REQ-1:0]             s_resp_ready,
   output logic [DATA_WIDTH-1:0]          s_resp_rdata,
   output logic                           s_resp_error,
   output logic                           m_req_valid,
   input  logic                           m_req_ready,
   output logic                           m_req_wr,
   output logic [ADDR_WIDTH-1:0]          m_req_addr,
   output logic [DATA_WIDTH-1:0]          m_req_wdata,
   input  logic                           m_resp_valid,
   output logic                           m_resp_ready,
   input  logic [DATA_WIDTH-1:0]          m_resp_rdata,
   input  logic                           m_resp_error,
   output logic                           arb_err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   ls_arb_state_t             state;
   logic [IW-1:0]             grant;
   logic [IW-1:0]             rr_ptr;
   logic [IW-1:0]             pick;
   logic [IW-1:0]             grant_inc;
   logic [IW-1:0]             head;
   logic [LS_ARB_MAX_REQ-1:0] req_ext;
   logic                      hs;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;

   // Winner selection for the next grant, evaluated from the live request vector.
   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = s_req_valid;
`ifdef LS_ARB_PRIO0_EN
      if (s_req_valid[0]) begin
         pick = '0;
      end else begin
         req_ext[0] = 1'b0;
         pick       = IW'(rr_pick(req_ext, LS_ARB_IDX_W'(rr_ptr)));
      end
`else
      pick = IW'(rr_pick(req_ext, LS_ARB_IDX_W'(rr_ptr)));
`endif
      grant_inc = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
   end

   // Grant FSM: latch a winner in IDLE, hold it until the downstream handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_req_valid && !fifo_full) begin
                  grant <= pick;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (hs) begin
                  state <= IDLE;
`ifdef LS_ARB_PRIO0_EN
                  if (grant != '0) rr_ptr <= grant_inc;
`else
                  rr_ptr <= grant_inc;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request path: the granted requester drives the downstream port directly.
   always_comb begin
      m_req_valid = (state == HOLD) && s_req_valid[grant];
      m_req_wr    = s_req_wr[grant];
      m_req_addr  = s_req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      m_req_wdata = s_req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      s_req_ready = '0;
      if (state == HOLD) s_req_ready[grant] = m_req_ready;
      hs = m_req_valid && m_req_ready;
   end

   // Response path: route to the oldest outstanding requester; stray responses are swallowed.
   always_comb begin
      s_resp_valid = '0;
      if (!fifo_empty) s_resp_valid[head] = m_resp_valid;
      m_resp_ready = !rst && (fifo_empty || s_resp_ready[head]);
      pop          = m_resp_valid && m_resp_ready && !fifo_empty;
      s_resp_rdata = m_resp_rdata;
      s_resp_error = m_resp_error;
   end

   // Sticky flag for a response arriving with nothing outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         arb_err <= 1'b0;
      end else if (m_resp_valid && fifo_empty) begin
         arb_err <= 1'b1;
      end
   end

   ls_tag_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hs),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
